// File: rtl/yutorina_dmac.sv
`default_nettype none
// ============================================================================
// yutorina_dmac : single-channel word DMA (bus master m2 + 4-register slave)
// Revision: 1.0
// ============================================================================
module yutorina_dmac #(
  parameter int COUNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        rdy_,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_w_data,
  input  logic [31:0] bus_r_data,
  input  logic        bus_rdy_,
  output logic        intr
);
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_AS   = 3'd2,
    RD_WAIT = 3'd3,
    WR_AS   = 3'd4,
    WR_WAIT = 3'd5,
    NEXT    = 3'd6
  } state_t;

  state_t             state;
  logic [29:0]        src_reg, dst_reg, src, dst;
  logic [COUNT_W-1:0] cnt_reg, cnt;
  logic               ie, done, src_fix, dst_fix;
  logic               busy, acc, wr_acc, ctrl_wr;
  logic               unused_bits;

  assign busy        = (state != IDLE);
  assign acc         = ~cs_ & ~as_;
  assign wr_acc      = acc & (rw == WRITE);
  assign ctrl_wr     = wr_acc & (addr == 2'd0);
  assign intr        = done & ie;
  assign unused_bits = ^w_data[31:30];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_   <= 1'b1;
      r_data <= '0;
    end else begin
      rdy_   <= ~acc;
      r_data <= '0;
      if (acc && rw == READ) begin
        case (addr)
          2'd0:    r_data <= {26'b0, dst_fix, src_fix, 1'b0, done, ie, busy};
          2'd1:    r_data <= {2'b0, src_reg};
          2'd2:    r_data <= {2'b0, dst_reg};
          default: r_data <= {{(32-COUNT_W){1'b0}}, cnt_reg};
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      cnt_reg    <= '0;
      src        <= '0;
      dst        <= '0;
      cnt        <= '0;
      ie         <= 1'b0;
      done       <= 1'b0;
      src_fix    <= 1'b0;
      dst_fix    <= 1'b0;
      bus_req_   <= 1'b1;
      bus_as_    <= 1'b1;
      bus_rw     <= READ;
      bus_addr   <= '0;
      bus_w_data <= '0;
    end else begin
      if (ctrl_wr) begin
        ie <= w_data[1];
        if (w_data[2]) done <= 1'b0;
      end
      if (wr_acc && !busy) begin
        case (addr)
          2'd0: begin
            src_fix <= w_data[4];
            dst_fix <= w_data[5];
          end
          2'd1:    src_reg <= w_data[29:0];
          2'd2:    dst_reg <= w_data[29:0];
          default: cnt_reg <= w_data[COUNT_W-1:0];
        endcase
      end
      // done assignments below follow the CPU clear so a same-cycle set wins
      case (state)
        IDLE: begin
          if (ctrl_wr && w_data[0]) begin
            src <= src_reg;
            dst <= dst_reg;
            cnt <= cnt_reg;
            if (cnt_reg == '0) begin
              done <= 1'b1;
            end else begin
              state    <= REQ;
              bus_req_ <= 1'b0;
            end
          end
        end
        REQ: begin
          if (!bus_grnt_) begin
            state    <= RD_AS;
            bus_as_  <= 1'b0;
            bus_rw   <= READ;
            bus_addr <= src;
          end
        end
        RD_AS: begin
          state   <= RD_WAIT;
          bus_as_ <= 1'b1;
        end
        RD_WAIT: begin
          if (!bus_rdy_) begin
            bus_w_data <= bus_r_data;
            state      <= WR_AS;
            bus_as_    <= 1'b0;
            bus_rw     <= WRITE;
            bus_addr   <= dst;
          end
        end
        WR_AS: begin
          state   <= WR_WAIT;
          bus_as_ <= 1'b1;
        end
        WR_WAIT: begin
          if (!bus_rdy_) begin
            cnt      <= cnt - COUNT_W'(1);
            if (!src_fix) src <= src + 30'd1;
            if (!dst_fix) dst <= dst + 30'd1;
            bus_req_ <= 1'b1;
            bus_rw   <= READ;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (cnt != '0) begin
            state    <= REQ;
            bus_req_ <= 1'b0;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_yutorina_dmac.sv
`default_nettype none
// tb_yutorina_dmac : directed self-checking bench with a bus arbiter/memory model.
module tb_yutorina_dmac;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] w_data = 32'd0;
  logic [31:0] r_data;
  logic        rdy_;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw;
  logic        bus_rdy_ = 1'b1;
  logic [29:0] bus_addr;
  logic [31:0] bus_w_data;
  logic [31:0] bus_r_data = 32'd0;
  logic        intr;

  int errors = 0, checks = 0;
  int gnt_delay = 0, rdy_delay = 0, gcnt = 0;
  int nrd = 0, nwr = 0, stable_err = 0, pulse_err = 0;
  bit req_seen = 0, pend = 0, as_prev = 0, prw = 0;
  int dly = 0;
  logic [29:0] paddr = '0;
  logic [31:0] pwd = '0;
  logic [31:0] mem [logic [29:0]];
  logic [29:0] rd_log [$];
  logic [29:0] wr_log [$];

  yutorina_dmac #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .w_data(w_data), .r_data(r_data), .rdy_(rdy_), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_w_data(bus_w_data), .bus_r_data(bus_r_data),
    .bus_rdy_(bus_rdy_), .intr(intr)
  );

  always #5 clk = ~clk;

  assign bus_grnt_ = !(!bus_req_ && gcnt >= gnt_delay);

  // arbiter, memory slave and bus-protocol monitor
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0;
      as_prev = 0;
      gcnt <= 0;
      bus_rdy_ <= 1'b1;
    end else begin
      if (!bus_req_) req_seen = 1;
      gcnt <= bus_req_ ? 0 : gcnt + 1;
      bus_rdy_ <= 1'b1;
      if (!bus_as_ && as_prev) pulse_err++;
      as_prev = !bus_as_;
      if (pend && bus_as_ && (bus_addr !== paddr || bus_rw !== prw ||
                              (!prw && bus_w_data !== pwd))) stable_err++;
      if (!bus_as_) begin
        pend = 1; dly = rdy_delay; paddr = bus_addr; prw = bus_rw; pwd = bus_w_data;
        if (bus_rw) begin nrd++; rd_log.push_back(bus_addr); end
        else begin nwr++; wr_log.push_back(bus_addr); end
      end else if (pend) begin
        dly--;
      end
      if (pend && dly == 0) begin
        pend = 0;
        bus_rdy_ <= 1'b0;
        if (prw) bus_r_data <= mem[paddr];
        else mem[paddr] = pwd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cs_ = 0; as_ = 0; rw = 0; addr = a; w_data = d;
    @(negedge clk); cs_ = 1; as_ = 1; rw = 1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); cs_ = 0; as_ = 0; rw = 1; addr = a;
    @(negedge clk); cs_ = 1; as_ = 1;
    chk("slave_rdy", {31'b0, rdy_}, 32'd0);
    d = r_data;
  endtask

  task automatic wait_intr(output int n);
    n = 0;
    while (intr !== 1'b1 && n < 300) begin @(negedge clk); n++; end
  endtask

  initial begin
    logic [31:0] d;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_rdy", {31'b0, rdy_}, 32'd1);
    chk("rst_bus_req", {31'b0, bus_req_}, 32'd1);
    chk("rst_bus_as", {31'b0, bus_as_}, 32'd1);
    chk("rst_bus_rw", {31'b0, bus_rw}, 32'd1);
    chk("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
    chk("rst_bus_w_data", bus_w_data, 32'd0);
    chk("rst_int", {31'b0, intr}, 32'd0);
    rst = 0;
    cpu_read(2'd0, d); chk("ctrl_after_reset", d, 32'd0);

    // basic copy
    for (int i = 0; i < 4; i++) mem[30'h100 + 30'(i)] = 32'hA0A0_0000 + 32'(i);
    cpu_write(2'd1, 32'h100);
    cpu_write(2'd2, 32'h200);
    cpu_write(2'd3, 32'd4);
    cpu_read(2'd3, d); chk("count_readback", d, 32'd4);
    cpu_write(2'd0, 32'h3);
    wait_intr(n);
    chk("basic_busy_cycles", 32'(n), 32'd24);
    chk("basic_int", {31'b0, intr}, 32'd1);
    chk("basic_reads", 32'(nrd), 32'd4);
    chk("basic_writes", 32'(nwr), 32'd4);
    chk("basic_dst0", mem[30'h200], 32'hA0A0_0000);
    chk("basic_dst1", mem[30'h201], 32'hA0A0_0001);
    chk("basic_dst2", mem[30'h202], 32'hA0A0_0002);
    chk("basic_dst3", mem[30'h203], 32'hA0A0_0003);
    cpu_read(2'd0, d); chk("basic_stat", d, 32'h6);
    cpu_write(2'd0, 32'h4);
    chk("clear_int", {31'b0, intr}, 32'd0);
    cpu_read(2'd0, d); chk("clear_stat", d, 32'h0);

    // COUNT=0 start
    cpu_write(2'd3, 32'd0);
    req_seen = 0;
    cpu_write(2'd0, 32'h3);
    chk("cnt0_int_next_cycle", {31'b0, intr}, 32'd1);
    repeat (5) @(negedge clk);
    chk("cnt0_no_req", {31'b0, req_seen}, 32'd0);
    cpu_read(2'd0, d); chk("cnt0_stat", d, 32'h6);

    // done-set and done-clear in the same cycle
    cpu_write(2'd0, 32'h4);
    cpu_write(2'd0, 32'h7);
    cpu_read(2'd0, d); chk("set_beats_clear", d, 32'h6);
    cpu_write(2'd0, 32'h4);

    // dst_fix
    for (int i = 0; i < 3; i++) mem[30'h300 + 30'(i)] = 32'hB0B0_0000 + 32'(i);
    rd_log.delete(); wr_log.delete();
    cpu_write(2'd1, 32'h300);
    cpu_write(2'd2, 32'h400);
    cpu_write(2'd3, 32'd3);
    cpu_write(2'd0, 32'h23);
    wait_intr(n);
    chk("fix_done", {31'b0, intr}, 32'd1);
    chk("fix_nwrites", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) chk("fix_wr_addr", {2'b0, wr_log[i]}, 32'h400);
      if (i < rd_log.size()) chk("fix_rd_addr", {2'b0, rd_log[i]}, 32'h300 + 32'(i));
    end
    chk("fix_dst_data", mem[30'h400], 32'hB0B0_0002);
    chk("fix_working_src", {2'b0, dut.src}, 32'h303);
    cpu_read(2'd1, d); chk("fix_src_reg", d, 32'h300);
    cpu_read(2'd0, d); chk("fix_stat", d, 32'h26);
    cpu_write(2'd0, 32'h4);

    // grant withheld 5 cycles, ready delayed 3 cycles
    gnt_delay = 5; rdy_delay = 3;
    nrd = 0; nwr = 0; stable_err = 0; pulse_err = 0;
    mem[30'h500] = 32'hC0C0_0000; mem[30'h501] = 32'hC0C0_0001;
    cpu_write(2'd1, 32'h500);
    cpu_write(2'd2, 32'h600);
    cpu_write(2'd3, 32'd2);
    cpu_write(2'd0, 32'h3);
    wait_intr(n);
    chk("slow_busy_cycles", 32'(n), 32'd34);
    chk("slow_reads", 32'(nrd), 32'd2);
    chk("slow_writes", 32'(nwr), 32'd2);
    chk("slow_stable", 32'(stable_err), 32'd0);
    chk("slow_as_pulse", 32'(pulse_err), 32'd0);
    chk("slow_dst0", mem[30'h600], 32'hC0C0_0000);
    chk("slow_dst1", mem[30'h601], 32'hC0C0_0001);
    cpu_write(2'd0, 32'h4);

    // address wrap plus SRC write while busy
    rdy_delay = 0;
    rd_log.delete();
    mem[30'h3FFF_FFFF] = 32'hD0D0_0000; mem[30'h0] = 32'hD0D0_0001;
    cpu_write(2'd1, 32'h3FFF_FFFF);
    cpu_write(2'd2, 32'h700);
    cpu_write(2'd3, 32'd2);
    cpu_write(2'd0, 32'h3);
    cpu_write(2'd1, 32'h55);
    wait_intr(n);
    chk("wrap_done", {31'b0, intr}, 32'd1);
    chk("wrap_nreads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      chk("wrap_rd0", {2'b0, rd_log[0]}, 32'h3FFF_FFFF);
      chk("wrap_rd1", {2'b0, rd_log[1]}, 32'h0);
    end
    chk("wrap_dst0", mem[30'h700], 32'hD0D0_0000);
    chk("wrap_dst1", mem[30'h701], 32'hD0D0_0001);
    cpu_read(2'd1, d); chk("busy_src_protect", d, 32'h3FFF_FFFF);
    cpu_write(2'd0, 32'h4);

    // reset while in RD_WAIT
    gnt_delay = 0; rdy_delay = 10;
    cpu_write(2'd1, 32'h100);
    cpu_write(2'd3, 32'd4);
    cpu_write(2'd0, 32'h1);
    n = 0;
    while (bus_as_ !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("rst_test_strobe_seen", {31'b0, bus_as_}, 32'd0);
    @(negedge clk);
    chk("rst_test_in_wait", {31'b0, bus_req_}, 32'd0);
    #2 rst = 1;
    #1;
    chk("async_rst_bus_req", {31'b0, bus_req_}, 32'd1);
    chk("async_rst_bus_as", {31'b0, bus_as_}, 32'd1);
    @(negedge clk); rst = 0;
    cpu_read(2'd0, d); chk("rst_busy_clear", d, 32'h0);
    cpu_read(2'd1, d); chk("rst_src_clear", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/yutorina_dmac.md
# yutorina_dmac

Single-channel word DMA controller for the yutorina chip. It copies a programmed number of 32-bit words from a source word address to a destination word address over the shared bus. It occupies bus master slot m2, whose request/grant lines are otherwise tied off, and exposes four control registers through a bus slave chip-select slot. Completion raises a level interrupt that is ORed into the CPU interrupt input.

## Interface
- COUNT_W, 16: width of the transfer-count register (1..30).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cs_  in  1  slave chip select, active low.
- as_  in  1  slave address strobe, active low.
- rw  in  1  slave direction; `READ` = read, `WRITE` = write.
- addr  in  2  slave register index.
- w_data  in  32  slave write data.
- r_data  out  32  slave read data; `ZERO` when not responding.
- rdy_  out  1  slave ready, active low.
- bus_req_  out  1  master bus request, active low.
- bus_grnt_  in  1  master bus grant, active low.
- bus_addr  out  30  master word address.
- bus_as_  out  1  master address strobe, active low.
- bus_rw  out  1  master direction.
- bus_w_data  out  32  master write data.
- bus_r_data  in  32  shared read data.
- bus_rdy_  in  1  shared ready, active low.
- int  out  1  interrupt, active high, level.

## Operation
- Registers:
  - 0 CTRL/STAT
    - bit0 start(W)/busy(R).
    - bit1 ie.
    - bit2 done (R; writing 1 clears it).
    - bit4 src_fix.
    - bit5 dst_fix.
    - Other bits read 0.
  - 1 SRC, bits [29:0].
  - 2 DST, bits [29:0].
  - 3 COUNT, bits [COUNT_W-1:0].
  - Unused bits read 0.
- While busy:
  - Writes to SRC, DST, COUNT, start, src_fix and dst_fix are ignored.
  - Writes to ie and done-clear take effect.
- Writing start=1 while idle latches the working copies of SRC, DST and COUNT and enters the transfer FSM.
- If COUNT=0 at start, no bus traffic occurs; done sets on the next cycle.
- FSM states:
  - IDLE
  - REQ: bus_req_=0. Advance to RD_AS when bus_grnt_ is sampled 0.
  - RD_AS: one cycle. bus_as_=0, bus_rw=`READ`, bus_addr=src.
  - RD_WAIT: address and rw held, bus_as_=1. On bus_rdy_=0, latch bus_r_data into the buffer.
  - WR_AS: one cycle. bus_as_=0, bus_rw=`WRITE`, bus_addr=dst, bus_w_data=buffer.
  - WR_WAIT: held until bus_rdy_=0. Then count--, src++ unless src_fix, dst++ unless dst_fix.
  - NEXT: bus_req_=1 for one cycle, which releases the bus between words. Go to REQ if count≠0, else to IDLE with done set.
- bus_req_ stays 0 from REQ through WR_WAIT.
- bus_rdy_ is ignored outside RD_WAIT and WR_WAIT.
- Addresses increment modulo 2^30; 3FFFFFFF wraps to 0.
- int = done & ie, combinational from registered flags.
- If done-set and a CPU done-clear occur in the same cycle, set wins.
- A slave that never returns rdy_ hangs the channel until reset. No abort mechanism exists.

## Timing
- Reset values:
  - Outputs: r_data=0, rdy_=1, bus_req_=1, bus_as_=1, bus_rw=`READ`, bus_addr=0, bus_w_data=0, int=0.
  - Registers: all 0. FSM in IDLE.
- Reset mid-transfer aborts immediately. The bus is released on reset assertion.
- Slave port: when cs_=0 and as_=0 are sampled, rdy_=0 for exactly one cycle on the next cycle, with r_data valid in that same cycle.
- A start write takes effect on the sampling edge. The FSM is in REQ (or sets done, if COUNT=0) on the following cycle.
- Per word: REQ(≥1) + RD_AS(1) + RD_WAIT(≥1) + WR_AS(1) + WR_WAIT(≥1) + NEXT(1). The minimum is 6 cycles per word.
- done and int rise in the cycle after the final NEXT.

## Test plan
- Basic copy:
  - Stimulus: SRC=0x100, DST=0x200, COUNT=4, ie=1, start; memory[0x100..0x103]=A0..A3; grant and ready immediate.
  - Required: DST holds A0..A3; exactly 4 read and 4 write strobes; busy for 24 cycles; int=1.
  - Then write CTRL=0x4: int=0, done=0.
- COUNT=0 start:
  - Required: no bus_req_ assertion; done=1 one cycle after the start write.
- dst_fix=1, COUNT=3:
  - Required: all writes go to the same DST address; SRC increments 3 times.
  - Afterwards the working src has advanced by 3, while the programmed SRC register still reads back its original value.
- Grant withheld 5 cycles, rdy_ delayed 3 cycles per access:
  - Required: addresses and data held stable throughout; each bus_as_ is a 1-cycle pulse; no extra strobes.
- Register protection and wrap:
  - Writing SRC while busy leaves SRC unchanged.
  - SRC=3FFFFFFF with COUNT=2 reads 3FFFFFFF then 0.
  - rst asserted in RD_WAIT: bus_req_ and bus_as_ return to 1 asynchronously; busy=0.
- Simultaneous done-set and done-clear: done stays 1.
